spi_slave_rx: RTL and testbench

SPI responder (mode 0, MSB first) that sits on the far end of the 40-bit SPI link the joystick/paddle master drives. It oversamples the SPI pins with the system clock, captures one 40-bit MOSI frame per chip-select window, and returns a 40-bit response on MISO in the same frame. A one-cycle `rx_valid` strobe hands each good frame to the game logic.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_pin_sync.sv | 35 +++
 rtl/spi_slave_rx.sv | 146 ++++++++++++++
 tb/tb_spi_slave_rx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI responder.
package spi_pkg;
  localparam int SPI_FRAME_BITS = 40;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } spi_state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// SYNC_STAGES-flop pin synchronizer with registered rise/fall detect; level after SYNC_STAGES, edges after SYNC_STAGES+1 cycles.
// No backpressure: free-running, one sample per clk50M cycle.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk50M,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder, 40-bit frames; rx_valid SYNC_STAGES+2 cycles after cs rises. SPI_SLAVE_LEN_CHECK_EN enables frame_err.
// No backpressure: rx_valid is a one-cycle strobe, the consumer must take rx_bytes when it fires.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = SPI_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk50M,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [FRAME_BITS-1:0] tx_bytes,
  output logic [FRAME_BITS-1:0] rx_bytes,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  logic w_sck_level_unused, w_sck_rise, w_sck_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk50M(clk50M), .rst_n(rst_n), .i_pin(sck),
    .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk50M(clk50M), .rst_n(rst_n), .i_pin(cs),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk50M(clk50M), .rst_n(rst_n), .i_pin(mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  spi_state_t r_state, w_state_nxt;
  logic w_start, w_stop, w_shift_in, w_shift_out;

  logic [FRAME_BITS-1:0] r_tx;
  logic [FRAME_BITS-1:0] r_rx;
  logic [FRAME_BITS-1:0] r_rx_bytes;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_miso;
  logic                  r_rx_valid;
  logic                  r_busy;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Leaving reset with cs already low must not join that frame, so wait for cs high first.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_IDLE: if (w_cs_level) w_state_nxt = IDLE;
      IDLE:      if (w_cs_fall)  w_state_nxt = ACTIVE;
      ACTIVE:    if (w_cs_rise)  w_state_nxt = IDLE;
      default:   w_state_nxt = WAIT_IDLE;
    endcase
  end

  always_comb begin
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_shift_in  = 1'b0;
    w_shift_out = 1'b0;
    case (r_state)
      IDLE:   w_start = w_cs_fall;
      ACTIVE: begin
        w_stop      = w_cs_rise;
        w_shift_in  = w_sck_rise & ~w_cs_rise;
        w_shift_out = w_sck_fall & ~w_cs_rise;
      end
      default: ;
    endcase
  end

`ifdef SPI_SLAVE_LEN_CHECK_EN
  logic r_frame_err;
`endif

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_bytes <= '0;
      r_bit_cnt  <= '0;
      r_miso     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
`ifdef SPI_SLAVE_LEN_CHECK_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
`ifdef SPI_SLAVE_LEN_CHECK_EN
      r_frame_err <= 1'b0;
`endif
      if (w_start) begin
        r_tx      <= tx_bytes;
        r_miso    <= tx_bytes[FRAME_BITS-1];
        r_bit_cnt <= '0;
        r_busy    <= 1'b1;
      end
      if (w_shift_in) begin
        r_rx <= {r_rx[FRAME_BITS-2:0], w_mosi};
        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + CW'(1);
      end
      // Zero fill means miso drops to 0 once the last response bit is shifted out.
      if (w_shift_out) begin
        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
        r_miso <= r_tx[FRAME_BITS-2];
      end
      if (w_stop) begin
        r_busy <= 1'b0;
        r_miso <= 1'b0;
        if (r_bit_cnt == CNT_FULL) begin
          r_rx_bytes <= r_rx;
          r_rx_valid <= 1'b1;
        end
`ifdef SPI_SLAVE_LEN_CHECK_EN
        else begin
          r_frame_err <= 1'b1;
        end
`endif
      end
    end
  end

  assign miso     = r_miso;
  assign rx_bytes = r_rx_bytes;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
`ifdef SPI_SLAVE_LEN_CHECK_EN
  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized SPI master driving spi_slave_rx; expected strobes go to a queue checked by a monitor.
module tb_spi_slave_rx;
  localparam int FB   = 40;
  localparam int SS   = 2;
  localparam int HALF = 32;

  logic          clk50M = 1'b0;
  logic          rst_n  = 1'b0;
  logic          sck    = 1'b0;
  logic          cs     = 1'b1;
  logic          mosi   = 1'b0;
  logic          miso;
  logic [FB-1:0] tx_bytes = '0;
  logic [FB-1:0] rx_bytes;
  logic          rx_valid;
  logic          busy;
  logic          frame_err;

  spi_slave_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_bytes(tx_bytes), .rx_bytes(rx_bytes), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err)
  );

  always #10 clk50M = ~clk50M;

  int cyc = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [FB-1:0] data;
    int            at;
  } ev_t;

  ev_t           exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [FB-1:0] last_good = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the oldest expected event.
  initial begin
    ev_t ev;
    bit  prev_valid = 1'b0;
    forever begin
      @(negedge clk50M);
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {62'd0, frame_err, rx_valid}, 64'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind", {62'd0, frame_err, rx_valid}, ev.is_err ? 64'd2 : 64'd1);
          chk("strobe_cycle", 64'(cyc), 64'(ev.at));
          if (!ev.is_err) chk("rx_bytes", 64'(rx_bytes), 64'(ev.data));
        end
      end
      if (rx_valid) chk("rx_valid_one_cycle", 64'(prev_valid), 64'd0);
      prev_valid = rx_valid;
    end
  end

  // One master frame: nbits bits MSB first from data; response expected from tx as latched at cs fall.
  task automatic frame(input int nbits, input logic [47:0] data, input logic [FB-1:0] tx,
                       input int chg_at, input logic [FB-1:0] chg_val, input int rst_at);
    bit  tail = 1'b0;
    ev_t ev;
    tx_bytes = tx;
    @(negedge clk50M);
    cs = 1'b0;
    repeat (16) @(negedge clk50M);
    chk("busy_in_frame", 64'(busy), 64'd1);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      repeat (HALF) @(negedge clk50M);
      chk("miso_bit", 64'(miso), (i < FB && !tail) ? 64'(tx[FB-1-i]) : 64'd0);
      sck = 1'b1;
      repeat (HALF) @(negedge clk50M);
      sck = 1'b0;
      if (i == chg_at) tx_bytes = chg_val;
      if (i == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk50M);
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_rx_bytes", 64'(rx_bytes), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        rst_n     = 1'b1;
        last_good = '0;
        tail      = 1'b1;
      end
    end
    repeat (16) @(negedge clk50M);
    cs = 1'b1;
    if (!tail) begin
      if (nbits == FB) begin
        ev = '{1'b0, data[FB-1:0], cyc + SS + 2};
        exp_q.push_back(ev);
        last_good = data[FB-1:0];
      end
`ifdef SPI_SLAVE_LEN_CHECK_EN
      else begin
        ev = '{1'b1, '0, cyc + SS + 2};
        exp_q.push_back(ev);
      end
`endif
    end
    repeat (16) @(negedge clk50M);
    chk("busy_after", 64'(busy), 64'd0);
    chk("miso_after", 64'(miso), 64'd0);
    chk("rx_bytes_held", 64'(rx_bytes), 64'(last_good));
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r_dat;
    logic [63:0] r_tx;
    int          len;

    repeat (3) @(negedge clk50M);
    chk("reset_miso", 64'(miso), 64'd0);
    chk("reset_rx_bytes", 64'(rx_bytes), 64'd0);
    chk("reset_rx_valid", 64'(rx_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk50M);

    frame(40, 48'h00A5_1234_5678, 40'h0F_F0AA_5501, -1, '0, -1);
    frame(40, 48'h005A_C3E1_0F96, 40'h12_3456_789A, 19, 40'hFF_FFFF_FFFF, -1);
    frame(40, 48'h0033_CC55_AA01, 40'hFF_FFFF_FFFF, -1, '0, -1);
    frame(39, 48'h0071_2345_6789, 40'h80_0000_0001, -1, '0, -1);
    frame(41, 48'h01F0_0F0F_F00F, 40'hC3_A55A_3CE7, -1, '0, -1);
    frame(40, 48'h00DE_ADBE_EF12, 40'hAA_5555_AAAA, -1, '0, 20);
    frame(40, 48'h0087_6543_2109, 40'h5A_A5F0_0F3C, -1, '0, -1);

    for (int k = 0; k < 8; k++) begin
      mosi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk50M);
      sck = 1'b1;
      chk("idle_miso", 64'(miso), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      repeat (HALF) @(negedge clk50M);
      sck = 1'b0;
    end
    repeat (16) @(negedge clk50M);

    for (int k = 0; k < 8; k++) begin
      r_dat = {$urandom, $urandom};
      r_tx  = {$urandom, $urandom};
      len   = ($urandom_range(0, 1) == 1) ? FB : int'($urandom_range(37, 43));
      frame(len, r_dat[47:0], r_tx[FB-1:0], int'($urandom_range(0, 39)), r_dat[FB-1:0], -1);
    end

    repeat (16) @(negedge clk50M);
    chk("pending_strobes", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
